alu_issue_buffer: RTL

Execute-stage front end sitting directly upstream of the ALU. It accepts decoded operations (opcode, two operands, destination register) from decode over a valid/ready handshake, buffers them in a 2-entry queue, drives the ALU combinationally from the queue head, and captures the ALU result with its destination tag into an output register that feeds writeback over a second valid/ready handshake. It decouples decode stalls from writeback stalls and sustains one operation per cycle.

---
 rtl/alu_issue_buffer_pkg.sv | 30 +++
 rtl/alu_issue_buffer_if.sv | 53 +++++
 rtl/alu_issue_buffer_issue_queue.sv | 39 +++
 rtl/alu_issue_buffer.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_issue_buffer_pkg.sv
// Shared definitions for the ALU issue buffer: widths, queue depth,
// the opcode mnemonic enum and the queue entry record.
package alu_issue_buffer_pkg;

  localparam int W           = 8;
  localparam int OPS         = 4;
  localparam int RA          = 3;
  localparam int ISSUE_DEPTH = 2;
  localparam int PTR_W       = 1;
  localparam int CNT_W       = 2;

  typedef enum logic [OPS-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_PASS = 4'd7
  } op_mne;

  typedef struct packed {
    op_mne           op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [RA-1:0]   dst;
  } queue_entry_t;

endpackage

// File: rtl/alu_issue_buffer_if.sv
// Handshake bundle between decode, the ALU and writeback.
// Bypass signals exist only when ALU_ISSUE_BYPASS_EN is defined.
// slave = the issue buffer's view, master = the surrounding pipeline's view.
interface alu_issue_buffer_if import alu_issue_buffer_pkg::*; ();

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  op_mne         in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [RA-1:0] in_dst;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  op_mne         alu_op;
  logic [W-1:0]  alu_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RA-1:0] out_dst;
`ifdef ALU_ISSUE_BYPASS_EN
  logic [RA-1:0] in_a_src;
  logic [RA-1:0] in_b_src;
  logic          in_a_is_reg;
  logic          in_b_is_reg;
  logic          wb_valid;
  logic [RA-1:0] wb_dst;
  logic [W-1:0]  wb_data;

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_dst, alu_out, out_ready,
    input  in_a_src, in_b_src, in_a_is_reg, in_b_is_reg, wb_valid, wb_dst, wb_data,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_dst
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_dst, alu_out, out_ready,
    output in_a_src, in_b_src, in_a_is_reg, in_b_is_reg, wb_valid, wb_dst, wb_data,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_dst
  );
`else
  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_dst, alu_out, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_dst
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_dst, alu_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_dst
  );
`endif

endinterface

// File: rtl/alu_issue_buffer_issue_queue.sv
// Two-entry circular operation queue: storage, 1-bit head/tail pointers
// and an occupancy count. The caller guarantees push only when not full
// and pop only when not empty.
module issue_queue import alu_issue_buffer_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  queue_entry_t     push_entry,
  output queue_entry_t     head_entry,
  output logic [CNT_W-1:0] count
);

  queue_entry_t     mem [ISSUE_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset; it is only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_entry;
  end

  assign head_entry = mem[head_ptr];

endmodule

// File: rtl/alu_issue_buffer.sv
// Execute-stage front end: buffers decoded ops in a 2-entry queue, drives
// the ALU from the queue head and registers the result for writeback.
// Optional macro ALU_ISSUE_BYPASS_EN forwards writeback data into operands
// at enqueue time.
module alu_issue_buffer import alu_issue_buffer_pkg::*; (
  input logic               clk,
  input logic               reset,
  alu_issue_buffer_if.slave bus
);

  queue_entry_t     enq_entry;
  queue_entry_t     head_entry;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             push;
  logic             issue;
  logic [W-1:0]     a_store;
  logic [W-1:0]     b_store;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [RA-1:0]    out_dst_q;

  assign bus.in_ready = (q_count < CNT_W'(ISSUE_DEPTH));
  assign q_empty      = (q_count == '0);
  assign push         = bus.in_valid && bus.in_ready && !bus.flush && !reset;
  assign issue        = !q_empty && (!out_valid_q || bus.out_ready) && !bus.flush;

`ifdef ALU_ISSUE_BYPASS_EN
  // Replace a register-sourced operand with in-flight writeback data.
  always_comb begin
    a_store = bus.in_a;
    b_store = bus.in_b;
    if (bus.wb_valid && bus.in_a_is_reg && (bus.in_a_src == bus.wb_dst)) a_store = bus.wb_data;
    if (bus.wb_valid && bus.in_b_is_reg && (bus.in_b_src == bus.wb_dst)) b_store = bus.wb_data;
  end
`else
  assign a_store = bus.in_a;
  assign b_store = bus.in_b;
`endif

  // Assemble the entry written at enqueue.
  always_comb begin
    enq_entry     = '0;
    enq_entry.op  = bus.in_op;
    enq_entry.a   = a_store;
    enq_entry.b   = b_store;
    enq_entry.dst = bus.in_dst;
  end

  issue_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .push       (push),
    .pop        (issue),
    .push_entry (enq_entry),
    .head_entry (head_entry),
    .count      (q_count)
  );

  // ALU sees the head entry, or zeros when nothing is queued.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = OP_ADD;
    if (!q_empty) begin
      bus.alu_a  = head_entry.a;
      bus.alu_b  = head_entry.b;
      bus.alu_op = head_entry.op;
    end
  end

  // Result register: flush drops the held result but keeps its data bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.alu_out;
      out_dst_q   <= head_entry.dst;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dst   = out_dst_q;

endmodule
